// File: rtl/sfp_norm.sv
// sfp_norm: row buffer with abs-sum capture and per-element normalization.
// Optional macro SFP_PEER_EN adds the peer core's abs-sum to each row total.
module sfp_norm #(
  parameter int bw_psum = 20,
  parameter int col     = 8,
  parameter int depth   = 8,
  parameter int frac    = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         acc,
  input  logic [col*bw_psum-1:0]       psum_in,
  input  logic                         div,
  input  logic [bw_psum+3:0]           peer_sum_in,
  output logic [bw_psum+3:0]           sum_out,
  output logic [col*bw_psum-1:0]       norm_out,
  output logic                         norm_vld,
  output logic [$clog2(depth):0]       count,
  output logic                         ovf_err,
  output logic                         udf_err
);

  localparam int aw = $clog2(depth);
  localparam int sw = bw_psum + 4;
  localparam int tw = bw_psum + 5;
  localparam int nw = bw_psum + 1 + frac;
  localparam int dw = (nw > tw) ? nw : tw;
  localparam logic [aw:0] full_cnt = (aw+1)'(depth);

  logic [col*bw_psum-1:0] row_mem [depth];
  logic [sw-1:0]          sum_mem [depth];

  logic [aw-1:0]          wp;
  logic [aw-1:0]          rp;
  logic [aw:0]            cnt;
  logic                   full;
  logic                   empty;
  logic                   do_wr;
  logic                   do_rd;
  logic [sw-1:0]          row_sum;
  logic [col*bw_psum-1:0] rd_row;
  logic [sw-1:0]          rd_sum;
  logic [tw-1:0]          total;
  logic [nw-1:0]          num;
  logic [col*bw_psum-1:0] norm_row;

  // Extra sign bit keeps the most negative input exact.
  function automatic logic [bw_psum:0] abs_f(
    input logic [bw_psum-1:0] e
  );
    logic [bw_psum:0] x;
    x = {e[bw_psum-1], e};
    return x[bw_psum] ? -x : x;
  endfunction

  assign full  = (cnt == full_cnt);
  assign empty = (cnt == '0);
  assign do_wr = acc && !full;
  assign do_rd = div && !empty;

  assign rd_row  = row_mem[rp];
  assign rd_sum  = sum_mem[rp];
  assign sum_out = empty ? '0 : rd_sum;
  assign count   = cnt;

`ifdef SFP_PEER_EN
  assign total = tw'(rd_sum) + tw'(peer_sum_in);
`else
  logic peer_unused;
  assign peer_unused = ^peer_sum_in;
  assign total = tw'(rd_sum);
`endif

  always_comb begin
    row_sum = '0;
    for (int i = 0; i < col; i++) begin
      row_sum = row_sum
              + sw'(abs_f(psum_in[i*bw_psum +: bw_psum]));
    end
  end

  // Quotient never exceeds 2^frac since |elem| <= total.
  always_comb begin
    num      = '0;
    norm_row = '0;
    for (int i = 0; i < col; i++) begin
      num = {abs_f(rd_row[i*bw_psum +: bw_psum]), {frac{1'b0}}};
      if (total != '0) begin
        norm_row[i*bw_psum +: bw_psum] =
          bw_psum'(dw'(num) / dw'(total));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr && !reset) begin
      row_mem[wp] <= psum_in;
      sum_mem[wp] <= row_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp       <= '0;
      rp       <= '0;
      cnt      <= '0;
      norm_out <= '0;
      norm_vld <= 1'b0;
      ovf_err  <= 1'b0;
      udf_err  <= 1'b0;
    end else begin
      if (do_wr) wp <= wp + 1'b1;
      if (do_rd) rp <= rp + 1'b1;
      unique case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      norm_vld <= do_rd;
      if (do_rd) norm_out <= norm_row;
      if (acc && full) ovf_err <= 1'b1;
      if (div && empty) udf_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sfp_norm.sv
// tb_sfp_norm: randomized + directed scoreboard bench for sfp_norm.
// Reference model keeps rows in a queue and normalizes with integer math.
module tb_sfp_norm;

  localparam int BW = 20;
  localparam int COL = 8;
  localparam int DEPTH = 8;
  localparam int RW = COL*BW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          acc = 1'b0;
  logic [RW-1:0] psum_in = '0;
  logic          div = 1'b0;
  logic [BW+3:0] peer_sum_in = '0;
  logic [BW+3:0] sum_out;
  logic [RW-1:0] norm_out;
  logic          norm_vld;
  logic [3:0]    count;
  logic          ovf_err;
  logic          udf_err;

  sfp_norm dut (
    .clk(clk), .reset(reset), .acc(acc), .psum_in(psum_in),
    .div(div), .peer_sum_in(peer_sum_in), .sum_out(sum_out),
    .norm_out(norm_out), .norm_vld(norm_vld), .count(count),
    .ovf_err(ovf_err), .udf_err(udf_err)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  logic [RW-1:0] mq[$];
  logic [RW-1:0] exq[$];
  bit m_ovf = 0;
  bit m_udf = 0;
  logic [RW-1:0] last_norm = '0;

  task automatic chk(input string nm, input logic [RW-1:0] got,
                     input logic [RW-1:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic longint absv(input logic [BW-1:0] e);
    longint v;
    v = longint'($signed(e));
    return (v < 0) ? -v : v;
  endfunction

  function automatic longint rsum(input logic [RW-1:0] r);
    longint s = 0;
    for (int i = 0; i < COL; i++) s += absv(r[i*BW +: BW]);
    return s;
  endfunction

  function automatic logic [RW-1:0] model_norm(
    input logic [RW-1:0] r, input logic [BW+3:0] peer);
    logic [RW-1:0] o = '0;
    longint tot = rsum(r);
    longint q;
`ifdef SFP_PEER_EN
    tot += longint'(peer);
`endif
    for (int i = 0; i < COL; i++) begin
      q = (tot == 0) ? 0 : (absv(r[i*BW +: BW]) * 256) / tot;
      o[i*BW +: BW] = BW'(q);
    end
    return o;
  endfunction

  function automatic logic [RW-1:0] fill(input int v);
    logic [RW-1:0] r;
    for (int i = 0; i < COL; i++) r[i*BW +: BW] = BW'(v);
    return r;
  endfunction

  function automatic logic [RW-1:0] e0(input int v);
    logic [RW-1:0] r = '0;
    r[BW-1:0] = BW'(v);
    return r;
  endfunction

  function automatic logic [RW-1:0] rnd_row();
    logic [RW-1:0] r;
    int mode = $urandom_range(0, 3);
    for (int i = 0; i < COL; i++) begin
      case (mode)
        0: r[i*BW +: BW] = BW'($urandom);
        1: r[i*BW +: BW] = BW'(int'($urandom_range(0, 40)) - 20);
        2: r[i*BW +: BW] = ($urandom_range(0, 3) == 0) ?
                           BW'($urandom) : '0;
        default: r[i*BW +: BW] = BW'($urandom_range(0, 1000));
      endcase
    end
    return r;
  endfunction

  // One cycle: check state seen now, drive, advance model to next edge.
  task automatic cyc(input bit a, input bit d, input logic [RW-1:0] row,
                     input logic [BW+3:0] peer, input bit rst);
    int n;
    @(negedge clk);
    n = mq.size();
    chk("count", RW'(count), RW'(n));
    chk("sum_out", RW'(sum_out), (n > 0) ? RW'(rsum(mq[0])) : '0);
    chk("ovf_err", RW'(ovf_err), RW'(m_ovf));
    chk("udf_err", RW'(udf_err), RW'(m_udf));
    acc = a;
    div = d;
    psum_in = row;
    peer_sum_in = peer;
    reset = rst;
    if (rst) begin
      mq.delete();
      m_ovf = 0;
      m_udf = 0;
    end else begin
      if (a && n == DEPTH) m_ovf = 1;
      if (d && n == 0) m_udf = 1;
      if (d && n > 0) begin
        exq.push_back(model_norm(mq[0], peer));
        void'(mq.pop_front());
      end
      if (a && n < DEPTH) mq.push_back(row);
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(0, 0, '0, '0, 0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        last_norm = '0;
      end else if (norm_vld !== 1'b0) begin
        if (exq.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL spurious_vld got=%h exp=none", norm_out);
        end else begin
          last_norm = exq.pop_front();
          chk("norm_out", norm_out, last_norm);
        end
      end else begin
        chk("norm_hold", norm_out, last_norm);
      end
    end
  end

  initial begin
    logic [RW-1:0] r;
    repeat (3) @(negedge clk);
    cyc(0, 0, '0, '0, 0);
    chk("rst_vld", RW'(norm_vld), '0);
    chk("rst_norm", norm_out, '0);

    cyc(1, 0, fill(1), '0, 0);
    cyc(0, 1, '0, '0, 0);
    idle(2);
    r = fill(4);
    r[BW-1:0] = BW'(-4);
    cyc(1, 0, r, '0, 0);
    cyc(1, 0, e0(-524288), '0, 0);
    cyc(0, 1, '0, '0, 0);
    cyc(0, 1, '0, '0, 0);
    cyc(1, 0, fill(1), 24'd8, 0);
    cyc(0, 1, '0, 24'd8, 0);
    cyc(1, 0, '0, '0, 0);
    cyc(0, 1, '0, '0, 0);
    idle(1);

    for (int k = 1; k <= 9; k++) cyc(1, 0, e0(k), '0, 0);
    for (int k = 1; k <= 9; k++) cyc(0, 1, '0, '0, 0);
    for (int k = 1; k <= 3; k++) cyc(1, 0, e0(k + 20), '0, 0);
    for (int k = 1; k <= 3; k++) cyc(0, 1, '0, '0, 0);

    cyc(0, 0, '0, '0, 1);
    for (int k = 1; k <= 3; k++) cyc(1, 0, rnd_row(), '0, 0);
    for (int k = 0; k < 4; k++) cyc(1, 1, rnd_row(), 24'(k), 0);
    cyc(1, 1, rnd_row(), '0, 0);
    for (int k = 0; k < 5; k++) cyc(1, 0, rnd_row(), '0, 0);
    cyc(1, 1, rnd_row(), '0, 0);
    cyc(0, 1, '0, '0, 0);
    cyc(0, 1, '0, '0, 1);
    cyc(0, 1, '0, '0, 0);
    cyc(1, 1, fill(3), '0, 0);
    cyc(0, 0, '0, '0, 1);

    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
          rnd_row(),
          ($urandom_range(0, 1) == 0) ? '0 : 24'($urandom_range(0, 1 << 20)),
          $urandom_range(0, 99) == 0);
    end
    cyc(0, 0, '0, '0, 0);
    while (mq.size() > 0) cyc(0, 1, '0, '0, 0);
    idle(3);
    chk("exq_drained", RW'(exq.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
